axis_vc_demux: RTL and testbench
================================

# axis_vc_demux

Parametrised AXI4-Stream virtual-channel demultiplexer for the CSI-2 receive path, placed between the packet-to-stream converter and the per-VC video pipelines. It routes each input beat to one of NUM_CH master ports by tdest, with a registered output slice per channel. It returns true per-channel backpressure, discards beats with unmapped tdest and counts them. Each channel's start-of-frame tuser[0] is either passed through or regenerated from a per-channel line counter.

## Interface
- WIDTH, 16: tdata width per beat.
- TUSER_WIDTH, 1: tuser width; bit 0 is SOF.
- TDEST_WIDTH, 10: tdest width.
- NUM_CH, 2: output channel count, 1..8.
- VC_BASE, 10'h1e0: channel c is selected when tdest == VC_BASE + c.
- SOF_MODE, 1: 0 = pass tuser through unchanged; 1 = regenerate tuser[0] per channel.
- FRAME_LINES, 3104: lines per frame used for SOF regeneration, 2..65535.
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low; clock aclk.
- s_axis_tvalid / s_axis_tready  in/out  1  input handshake.
- s_axis_tdata  in  WIDTH  input pixel data.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  TUSER_WIDTH  input sideband; bit 0 is SOF.
- s_axis_tdest  in  TDEST_WIDTH  virtual channel / data type.
- m_axis_tvalid  out  NUM_CH  per-channel valid; bit c belongs to channel c.
- m_axis_tready  in  NUM_CH  per-channel ready.
- m_axis_tdata  out  NUM_CH*WIDTH  channel c occupies [c*WIDTH +: WIDTH].
- m_axis_tlast  out  NUM_CH  per-channel end of line.
- m_axis_tuser  out  NUM_CH*TUSER_WIDTH  per-channel sideband.
- m_axis_tdest  out  NUM_CH*TDEST_WIDTH  tdest forwarded unchanged.
- drop_cnt  out  16  count of discarded beats; saturates at 16'hFFFF.

## Operation
- Decode: sel_hit = (s_axis_tdest - VC_BASE) < NUM_CH, using unsigned compare at TDEST_WIDTH; sel = low bits of the difference.
- Output slice per channel: one register stage holding valid, data, last, user and dest. slot_free[c] = !m_axis_tvalid[c] || m_axis_tready[c].
- s_axis_tready = sel_hit ? slot_free[sel] : 1. It depends only on the decode and on the selected channel. Unselected channels never stall the input.
- Accept occurs when s_axis_tvalid && s_axis_tready.
  - Hit: load channel sel and set its valid.
  - Miss: discard the beat and increment drop_cnt, saturating.
- m_axis_tvalid[c] clears when m_axis_tready[c] is high and no new beat is loaded into channel c in that cycle. If a new beat is loaded in the same cycle, the slot is overwritten and valid stays high.
- Per-channel state: line_cnt[c] (16 bit) and sof_pend[c].
  - On each accepted beat for channel c: base = s_axis_tuser[0] ? 0 : line_cnt[c].
  - If s_axis_tlast: when base+1 == FRAME_LINES, line_cnt[c] becomes 0 and sof_pend[c] is set; otherwise line_cnt[c] becomes base+1.
  - If not s_axis_tlast: line_cnt[c] becomes base.
  - sof_pend[c] clears on any accepted beat for c that does not itself set it.
- Output tuser:
  - SOF_MODE=0: registered tuser equals the input tuser.
  - SOF_MODE=1: registered tuser[0] = s_axis_tuser[0] | sof_pend[c]. Upper tuser bits pass through.
- Counters of different channels are fully independent. Interleaved VCs do not disturb each other.

## Timing
- Latency: input accept to m_axis_tvalid[c] is 1 cycle.
- Throughput: 1 beat/cycle per channel while its ready is held high.
- Reset values: all m_axis_tvalid = 0; tdata, tuser, tlast and tdest = 0; line_cnt = 0; sof_pend = 1 (the first beat after reset is marked SOF in mode 1); drop_cnt = 0.
- Reset mid-operation: in-flight slice contents are lost. s_axis_tready during reset equals the reset-state decode (slots empty, so 1).
- AXI rules:
  - m_axis_tvalid[c] never drops without a handshake.
  - Registered payload is stable while tvalid=1 and tready=0.
  - s_axis_tready may combinationally depend on s_axis_tdest and m_axis_tready.
- Simultaneous tuser[0] and tlast on one beat (1-line frame): base=0, line_cnt becomes 1; if FRAME_LINES would be reached, the wrap rule applies.
- drop_cnt at 16'hFFFF holds its value.

## Test plan
- Reset release, then 4 beats tdest=1e0 with tdata 1..4 and m_tready=2'b11 -> m0 shows 1..4 with 1-cycle latency, m1 idle. With SOF_MODE=1, tuser[0]=1 only on the beat with tdata 1.
- Alternate tdest 1e0/1e1 every beat with m_tready[1]=0 for 5 cycles:
  - s_tready drops only on 1e1 beats, and only while the m1 slot is full.
  - m1 payload stays stable while stalled.
  - No beats are lost or duplicated on either channel.
- tdest=1e5, 3 beats -> s_tready=1, nothing on any output, drop_cnt=3. Drive 65540 drops -> drop_cnt=FFFF.
- FRAME_LINES=4, SOF_MODE=1, 9 lines of 2 beats on 1e1 with tuser=0 -> tuser[0]=1 on the first beats of lines 0, 4 and 8 only.
- Input tuser[0]=1 mid-frame at line 2 on 1e0 -> output SOF on that beat; line_cnt restarts, so the next regenerated SOF comes FRAME_LINES lines later. The 1e1 counter is unchanged.
- SOF_MODE=0 with the same stimulus -> output tuser equals input tuser exactly; the count and wrap logic has no effect on outputs.

Source files
------------

// File: rtl/axis_vc_demux.sv
// AXI4-Stream virtual-channel demultiplexer: routes beats by tdest into per-channel
// register slices, drops unmapped beats, and optionally regenerates SOF per channel.

module axis_vc_demux_ch #(
  parameter int WIDTH       = 16,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 10,
  parameter int SOF_MODE    = 1,
  parameter int FRAME_LINES = 3104
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   load,
  input  logic [WIDTH-1:0]       s_tdata,
  input  logic                   s_tlast,
  input  logic [TUSER_WIDTH-1:0] s_tuser,
  input  logic [TDEST_WIDTH-1:0] s_tdest,
  input  logic                   m_tready,
  output logic                   m_tvalid,
  output logic [WIDTH-1:0]       m_tdata,
  output logic                   m_tlast,
  output logic [TUSER_WIDTH-1:0] m_tuser,
  output logic [TDEST_WIDTH-1:0] m_tdest,
  output logic                   slot_free
);

  logic                   vld_q,  vld_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   last_q, last_d;
  logic [TUSER_WIDTH-1:0] user_q, user_d;
  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [15:0]            line_q, line_d;
  logic                   pend_q, pend_d;
  logic [15:0]            base;
  logic [16:0]            nxt;
  logic [TUSER_WIDTH-1:0] user_in;

  assign slot_free = !vld_q || m_tready;

  always_comb begin
    user_in = s_tuser;
    if (SOF_MODE != 0) user_in[0] = s_tuser[0] | pend_q;
    base   = s_tuser[0] ? 16'd0 : line_q;
    nxt    = {1'b0, base} + 17'd1;
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    user_d = user_q;
    dest_d = dest_q;
    line_d = line_q;
    pend_d = pend_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = s_tdata;
      last_d = s_tlast;
      user_d = user_in;
      dest_d = s_tdest;
      pend_d = 1'b0;
      if (s_tlast) begin
        // Last line of the frame: wrap and flag the next beat as SOF.
        if (nxt == 17'(FRAME_LINES)) begin
          line_d = 16'd0;
          pend_d = 1'b1;
        end else begin
          line_d = nxt[15:0];
        end
      end else begin
        line_d = base;
      end
    end else if (m_tready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      user_q <= '0;
      dest_q <= '0;
      line_q <= 16'd0;
      pend_q <= 1'b1;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      user_q <= user_d;
      dest_q <= dest_d;
      line_q <= line_d;
      pend_q <= pend_d;
    end
  end

  assign m_tvalid = vld_q;
  assign m_tdata  = data_q;
  assign m_tlast  = last_q;
  assign m_tuser  = user_q;
  assign m_tdest  = dest_q;

endmodule

module axis_vc_demux #(
  parameter int                     WIDTH       = 16,
  parameter int                     TUSER_WIDTH = 1,
  parameter int                     TDEST_WIDTH = 10,
  parameter int                     NUM_CH      = 2,
  parameter logic [TDEST_WIDTH-1:0] VC_BASE     = 10'h1e0,
  parameter int                     SOF_MODE    = 1,
  parameter int                     FRAME_LINES = 3104
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [WIDTH-1:0]              s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]        s_axis_tuser,
  input  logic [TDEST_WIDTH-1:0]        s_axis_tdest,
  output logic [NUM_CH-1:0]             m_axis_tvalid,
  input  logic [NUM_CH-1:0]             m_axis_tready,
  output logic [NUM_CH*WIDTH-1:0]       m_axis_tdata,
  output logic [NUM_CH-1:0]             m_axis_tlast,
  output logic [NUM_CH*TUSER_WIDTH-1:0] m_axis_tuser,
  output logic [NUM_CH*TDEST_WIDTH-1:0] m_axis_tdest,
  output logic [15:0]                   drop_cnt
);

  localparam int SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [TDEST_WIDTH-1:0] NCH_T = TDEST_WIDTH'(NUM_CH);

  logic [TDEST_WIDTH-1:0] diff;
  logic                   sel_hit;
  logic [SELW-1:0]        sel;
  logic [NUM_CH-1:0]      slot_free;
  logic [NUM_CH-1:0]      load;
  logic                   acc;
  logic [15:0]            drop_q, drop_d;

  // Wrapping subtract makes tdest below VC_BASE fall out of range as well.
  assign diff          = s_axis_tdest - VC_BASE;
  assign sel_hit       = diff < NCH_T;
  assign sel           = diff[SELW-1:0];
  assign s_axis_tready = sel_hit ? slot_free[sel] : 1'b1;
  assign acc           = s_axis_tvalid && s_axis_tready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign load[c] = acc && sel_hit && (sel == SELW'(c));

    axis_vc_demux_ch #(
      .WIDTH(WIDTH), .TUSER_WIDTH(TUSER_WIDTH), .TDEST_WIDTH(TDEST_WIDTH),
      .SOF_MODE(SOF_MODE), .FRAME_LINES(FRAME_LINES)
    ) u_ch (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .load      (load[c]),
      .s_tdata   (s_axis_tdata),
      .s_tlast   (s_axis_tlast),
      .s_tuser   (s_axis_tuser),
      .s_tdest   (s_axis_tdest),
      .m_tready  (m_axis_tready[c]),
      .m_tvalid  (m_axis_tvalid[c]),
      .m_tdata   (m_axis_tdata[c*WIDTH +: WIDTH]),
      .m_tlast   (m_axis_tlast[c]),
      .m_tuser   (m_axis_tuser[c*TUSER_WIDTH +: TUSER_WIDTH]),
      .m_tdest   (m_axis_tdest[c*TDEST_WIDTH +: TDEST_WIDTH]),
      .slot_free (slot_free[c])
    );
  end

  always_comb begin
    drop_d = drop_q;
    if (acc && !sel_hit && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) drop_q <= 16'd0;
    else          drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_axis_vc_demux.sv
// Directed bench: dut_a regenerates SOF, dut_b passes tuser through; both use
// FRAME_LINES=4 and share the same input stimulus.

module tb_axis_vc_demux;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_tvalid;
  logic [15:0] s_tdata;
  logic        s_tlast;
  logic [0:0]  s_tuser;
  logic [9:0]  s_tdest;
  logic [1:0]  m_tready;

  logic        s_tready_a, s_tready_b;
  logic [1:0]  m_tvalid_a, m_tvalid_b;
  logic [31:0] m_tdata_a, m_tdata_b;
  logic [1:0]  m_tlast_a, m_tlast_b;
  logic [1:0]  m_tuser_a, m_tuser_b;
  logic [19:0] m_tdest_a, m_tdest_b;
  logic [15:0] drop_a, drop_b;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_vc_demux #(.FRAME_LINES(4), .SOF_MODE(1)) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tdest(s_tdest),
    .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata_a),
    .m_axis_tlast(m_tlast_a), .m_axis_tuser(m_tuser_a), .m_axis_tdest(m_tdest_a),
    .drop_cnt(drop_a)
  );

  axis_vc_demux #(.FRAME_LINES(4), .SOF_MODE(0)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tdest(s_tdest),
    .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata_b),
    .m_axis_tlast(m_tlast_b), .m_axis_tuser(m_tuser_b), .m_axis_tdest(m_tdest_b),
    .drop_cnt(drop_b)
  );

  task automatic clk();
    @(posedge aclk);
    #1;
  endtask

  task automatic put(input logic [9:0] d, input logic [15:0] dat, input logic l, input logic u);
    s_tvalid = 1'b1;
    s_tdest  = d;
    s_tdata  = dat;
    s_tlast  = l;
    s_tuser  = u;
    #1;
  endtask

  task automatic send(input logic [9:0] d, input logic [15:0] dat, input logic l, input logic u);
    put(d, dat, l, u);
    clk();
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    m_tready = 2'b11;
    put(10'h1e1, 16'hbeef, 1'b0, 1'b0);
    repeat (3) clk();
    checks += 6;
    if (m_tvalid_a !== 2'b00) begin errors++; $display("FAIL rst_vld_a got %b exp 00", m_tvalid_a); end
    if (m_tvalid_b !== 2'b00) begin errors++; $display("FAIL rst_vld_b got %b exp 00", m_tvalid_b); end
    if (m_tdata_a !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", m_tdata_a); end
    if (m_tuser_a !== 2'b00 || m_tlast_a !== 2'b00 || m_tdest_a !== 20'd0) begin
      errors++; $display("FAIL rst_side got u=%b l=%b d=%h exp 0", m_tuser_a, m_tlast_a, m_tdest_a);
    end
    if (drop_a !== 16'd0) begin errors++; $display("FAIL rst_drop got %h exp 0", drop_a); end
    if (s_tready_a !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", s_tready_a); end
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    clk();
  endtask

  task automatic test_basic();
    m_tready = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      send(10'h1e0, 16'(i), 1'b0, 1'b0);
      checks += 4;
      if (m_tvalid_a !== 2'b01) begin errors++; $display("FAIL basic_vld[%0d] got %b exp 01", i, m_tvalid_a); end
      if (m_tdata_a[15:0] !== 16'(i)) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, m_tdata_a[15:0], i); end
      if (m_tuser_a[0] !== (i == 1)) begin errors++; $display("FAIL basic_sof[%0d] got %b exp %b", i, m_tuser_a[0], i == 1); end
      if (m_tdest_a[9:0] !== 10'h1e0 || m_tuser_b !== 2'b00) begin
        errors++; $display("FAIL basic_side[%0d] got d=%h ub=%b exp 1e0/00", i, m_tdest_a[9:0], m_tuser_b);
      end
    end
    clk();
    checks++;
    if (m_tvalid_a !== 2'b00) begin errors++; $display("FAIL basic_idle got %b exp 00", m_tvalid_a); end
  endtask

  task automatic test_backpressure();
    m_tready = 2'b01;
    send(10'h1e0, 16'h10, 1'b0, 1'b0);
    checks += 2;
    if (m_tvalid_a !== 2'b01) begin errors++; $display("FAIL bp1_vld got %b exp 01", m_tvalid_a); end
    if (m_tdata_a[15:0] !== 16'h10) begin errors++; $display("FAIL bp1_d0 got %h exp 10", m_tdata_a[15:0]); end

    put(10'h1e1, 16'h20, 1'b0, 1'b0);
    checks++;
    if (s_tready_a !== 1'b1) begin errors++; $display("FAIL bp2_rdy got %b exp 1", s_tready_a); end
    clk();
    checks += 3;
    if (m_tvalid_a !== 2'b10) begin errors++; $display("FAIL bp2_vld got %b exp 10", m_tvalid_a); end
    if (m_tdata_a[31:16] !== 16'h20) begin errors++; $display("FAIL bp2_d1 got %h exp 20", m_tdata_a[31:16]); end
    if (m_tuser_a[1] !== 1'b1) begin errors++; $display("FAIL bp2_sof got %b exp 1", m_tuser_a[1]); end

    put(10'h1e0, 16'h11, 1'b0, 1'b0);
    checks++;
    if (s_tready_a !== 1'b1) begin errors++; $display("FAIL bp3_rdy got %b exp 1", s_tready_a); end
    clk();
    checks += 2;
    if (m_tvalid_a !== 2'b11) begin errors++; $display("FAIL bp3_vld got %b exp 11", m_tvalid_a); end
    if (m_tdata_a !== {16'h20, 16'h11}) begin errors++; $display("FAIL bp3_data got %h exp 00200011", m_tdata_a); end

    put(10'h1e1, 16'h21, 1'b0, 1'b0);
    checks++;
    if (s_tready_a !== 1'b0) begin errors++; $display("FAIL bp4_rdy got %b exp 0", s_tready_a); end
    clk();
    checks += 2;
    if (m_tvalid_a !== 2'b10) begin errors++; $display("FAIL bp4_vld got %b exp 10", m_tvalid_a); end
    if (m_tdata_a[31:16] !== 16'h20 || m_tuser_a[1] !== 1'b1) begin
      errors++; $display("FAIL bp4_stable got %h/%b exp 20/1", m_tdata_a[31:16], m_tuser_a[1]);
    end

    put(10'h1e0, 16'h12, 1'b0, 1'b0);
    checks++;
    if (s_tready_a !== 1'b1) begin errors++; $display("FAIL bp5_rdy got %b exp 1", s_tready_a); end
    clk();
    checks += 2;
    if (m_tvalid_a !== 2'b11) begin errors++; $display("FAIL bp5_vld got %b exp 11", m_tvalid_a); end
    if (m_tdata_a !== {16'h20, 16'h12}) begin errors++; $display("FAIL bp5_data got %h exp 00200012", m_tdata_a); end

    put(10'h1e1, 16'h21, 1'b0, 1'b0);
    checks++;
    if (s_tready_a !== 1'b0) begin errors++; $display("FAIL bp6_rdy_stall got %b exp 0", s_tready_a); end
    m_tready = 2'b11;
    #1;
    checks++;
    if (s_tready_a !== 1'b1) begin errors++; $display("FAIL bp6_rdy got %b exp 1", s_tready_a); end
    clk();
    checks += 2;
    if (m_tvalid_a !== 2'b10) begin errors++; $display("FAIL bp6_vld got %b exp 10", m_tvalid_a); end
    if (m_tdata_a[31:16] !== 16'h21 || m_tuser_a[1] !== 1'b0) begin
      errors++; $display("FAIL bp6_d1 got %h/%b exp 21/0", m_tdata_a[31:16], m_tuser_a[1]);
    end
    s_tvalid = 1'b0;
    clk();
    checks++;
    if (m_tvalid_a !== 2'b00) begin errors++; $display("FAIL bp_drain got %b exp 00", m_tvalid_a); end
  endtask

  task automatic test_drop();
    logic [9:0] miss [3];
    miss[0] = 10'h1e5;
    miss[1] = 10'h1df;
    miss[2] = 10'h1e2;
    m_tready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      put(miss[i], 16'h77, 1'b0, 1'b0);
      checks++;
      if (s_tready_a !== 1'b1) begin errors++; $display("FAIL drop_rdy[%0d] got %b exp 1", i, s_tready_a); end
      clk();
      checks++;
      if (m_tvalid_a !== 2'b00) begin errors++; $display("FAIL drop_vld[%0d] got %b exp 00", i, m_tvalid_a); end
    end
    checks += 2;
    if (drop_a !== 16'd3) begin errors++; $display("FAIL drop_cnt3_a got %0d exp 3", drop_a); end
    if (drop_b !== 16'd3) begin errors++; $display("FAIL drop_cnt3_b got %0d exp 3", drop_b); end
    put(10'h1e5, 16'h0, 1'b0, 1'b0);
    repeat (65540) clk();
    checks++;
    if (drop_a !== 16'hFFFF) begin errors++; $display("FAIL drop_sat got %h exp FFFF", drop_a); end
    clk();
    s_tvalid = 1'b0;
    checks++;
    if (drop_a !== 16'hFFFF) begin errors++; $display("FAIL drop_hold got %h exp FFFF", drop_a); end
  endtask

  task automatic test_reset_mid();
    m_tready = 2'b00;
    send(10'h1e0, 16'h55, 1'b1, 1'b0);
    checks++;
    if (m_tvalid_a !== 2'b01) begin errors++; $display("FAIL rmid_pre got %b exp 01", m_tvalid_a); end
    aresetn = 1'b0;
    clk();
    checks += 2;
    if (m_tvalid_a !== 2'b00 || m_tdata_a !== 32'd0) begin
      errors++; $display("FAIL rmid_slot got %b/%h exp 00/0", m_tvalid_a, m_tdata_a);
    end
    if (drop_a !== 16'd0) begin errors++; $display("FAIL rmid_drop got %h exp 0", drop_a); end
    aresetn  = 1'b1;
    m_tready = 2'b11;
    clk();
  endtask

  task automatic test_sof_regen();
    for (int l = 0; l < 9; l++) begin
      for (int b = 0; b < 2; b++) begin
        send(10'h1e1, 16'(l * 2 + b), b[0], 1'b0);
        checks += 3;
        if (m_tvalid_a[1] !== 1'b1 || m_tdata_a[31:16] !== 16'(l * 2 + b) || m_tlast_a[1] !== b[0]) begin
          errors++; $display("FAIL regen_beat[%0d.%0d] got v=%b d=%h l=%b", l, b, m_tvalid_a[1], m_tdata_a[31:16], m_tlast_a[1]);
        end
        if (m_tuser_a[1] !== (b == 0 && l % 4 == 0)) begin
          errors++; $display("FAIL regen_sof[%0d.%0d] got %b exp %b", l, b, m_tuser_a[1], b == 0 && l % 4 == 0);
        end
        if (m_tuser_b[1] !== 1'b0) begin errors++; $display("FAIL pass_sof[%0d.%0d] got %b exp 0", l, b, m_tuser_b[1]); end
      end
    end
  endtask

  task automatic test_sof_input();
    logic u;
    for (int l = 0; l < 7; l++) begin
      for (int b = 0; b < 2; b++) begin
        u = (l == 2 && b == 0);
        send(10'h1e0, 16'(16'h100 + l * 2 + b), b[0], u);
        checks += 2;
        if (m_tuser_a[0] !== (b == 0 && (l == 0 || l == 2 || l == 6))) begin
          errors++; $display("FAIL insof_a[%0d.%0d] got %b exp %b", l, b, m_tuser_a[0], b == 0 && (l == 0 || l == 2 || l == 6));
        end
        if (m_tuser_b[0] !== u) begin errors++; $display("FAIL insof_b[%0d.%0d] got %b exp %b", l, b, m_tuser_b[0], u); end
      end
    end
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 2; b++) begin
        send(10'h1e1, 16'(16'h200 + l * 2 + b), b[0], 1'b0);
        checks++;
        if (m_tuser_a[1] !== (b == 0 && l == 3)) begin
          errors++; $display("FAIL vc1_indep[%0d.%0d] got %b exp %b", l, b, m_tuser_a[1], b == 0 && l == 3);
        end
      end
    end
    send(10'h1e0, 16'h300, 1'b1, 1'b1);
    checks++;
    if (m_tuser_a[0] !== 1'b1 || m_tuser_b[0] !== 1'b1 || m_tlast_a[0] !== 1'b1) begin
      errors++; $display("FAIL oneline got a=%b b=%b l=%b exp 1/1/1", m_tuser_a[0], m_tuser_b[0], m_tlast_a[0]);
    end
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 2; b++) begin
        send(10'h1e0, 16'(16'h310 + l * 2 + b), b[0], 1'b0);
        checks++;
        if (m_tuser_a[0] !== (b == 0 && l == 3)) begin
          errors++; $display("FAIL oneline_wrap[%0d.%0d] got %b exp %b", l, b, m_tuser_a[0], b == 0 && l == 3);
        end
      end
    end
  endtask

  initial begin
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
    s_tdest  = '0;
    m_tready = 2'b11;
    aresetn  = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_sof_regen();
    test_sof_input();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
